// File: rtl/cursor_pkg.sv
// Shared types, widths and the clamp helper for the cursor position controller.
package cursor_pkg;

    localparam int CUR_W = 11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } rep_state_t;

    // Signed 12-bit compare so a negative candidate pins to lo instead of wrapping.
    function automatic logic [CUR_W-1:0] clamp_axis(
        input logic signed [CUR_W:0] value,
        input logic signed [CUR_W:0] lo,
        input logic signed [CUR_W:0] hi
    );
        if (value < lo) begin
            return lo[CUR_W-1:0];
        end else if (value > hi) begin
            return hi[CUR_W-1:0];
        end else begin
            return value[CUR_W-1:0];
        end
    endfunction

endpackage

// File: rtl/cursor_repeat_timer.sv
// Key auto-repeat FSM: decides on each frame_start whether the cursor takes a step.
module cursor_repeat_timer
    import cursor_pkg::*;
#(
    parameter int HOLD_FRAMES   = 15,
    parameter int REPEAT_FRAMES = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_start,
    input  logic [3:0] dv,
    output logic       step_now
);

    localparam logic [1:0] ST_IDLE   = 2'(IDLE);
    localparam logic [1:0] ST_HOLD   = 2'(HOLD);
    localparam logic [1:0] ST_REPEAT = 2'(REPEAT);

    localparam int MAX_FRAMES = (HOLD_FRAMES > REPEAT_FRAMES) ? HOLD_FRAMES : REPEAT_FRAMES;
    localparam int CNT_W      = $clog2(MAX_FRAMES + 1);

    logic [1:0]       state, next_state;
    logic [CNT_W-1:0] cnt, next_cnt;
    logic [3:0]       pv;

    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        step_now   = 1'b0;
        if (frame_start) begin
            case (state)
                ST_IDLE: begin
                    if (dv != 4'd0) begin
                        step_now   = 1'b1;
                        next_state = ST_HOLD;
                        next_cnt   = '0;
                    end
                end
                ST_HOLD: begin
                    if (dv == 4'd0) begin
                        next_state = ST_IDLE;
                        next_cnt   = '0;
                    end else if (dv != pv) begin
                        step_now = 1'b1;
                        next_cnt = '0;
                    end else if (cnt == CNT_W'(HOLD_FRAMES - 1)) begin
                        step_now   = 1'b1;
                        next_state = ST_REPEAT;
                        next_cnt   = '0;
                    end else begin
                        next_cnt = cnt + CNT_W'(1);
                    end
                end
                ST_REPEAT: begin
                    if (dv == 4'd0) begin
                        next_state = ST_IDLE;
                        next_cnt   = '0;
                    end else if (dv != pv) begin
                        step_now   = 1'b1;
                        next_state = ST_HOLD;
                        next_cnt   = '0;
                    end else if (cnt == CNT_W'(REPEAT_FRAMES - 1)) begin
                        step_now = 1'b1;
                        next_cnt = '0;
                    end else begin
                        next_cnt = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    next_state = ST_IDLE;
                    next_cnt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            pv    <= 4'd0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
            if (frame_start) begin
                pv <= dv;
            end
        end
    end

endmodule

// File: rtl/cursor_position_ctrl.sv
// Cursor position for the VGA overlay: key auto-repeat plus absolute sets, clamped
// inside the border and committed only on frame_start.
module cursor_position_ctrl
    import cursor_pkg::*;
#(
    parameter int W             = 640,
    parameter int H             = 480,
    parameter int STEP          = 1,
    parameter int HOLD_FRAMES   = 15,
    parameter int REPEAT_FRAMES = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_start,
    input  logic             dir_up,
    input  logic             dir_down,
    input  logic             dir_left,
    input  logic             dir_right,
    input  logic             set_valid,
    input  logic [CUR_W-1:0] set_x,
    input  logic [CUR_W-1:0] set_y,
    output logic             set_ready,
    output logic [CUR_W-1:0] cursorX,
    output logic [CUR_W-1:0] cursorY,
    output logic             moved
);

    localparam logic signed [CUR_W:0] X_MIN  = (CUR_W+1)'(2);
    localparam logic signed [CUR_W:0] X_MAX  = (CUR_W+1)'(W - 4);
    localparam logic signed [CUR_W:0] Y_MIN  = (CUR_W+1)'(2);
    localparam logic signed [CUR_W:0] Y_MAX  = (CUR_W+1)'(H - 2);
    localparam logic signed [CUR_W:0] STEP_S = (CUR_W+1)'(STEP);

    logic             go_right, go_left, go_down, go_up;
    logic [3:0]       dv;
    logic             step_now;
    logic signed [CUR_W:0] step_dx, step_dy;
    logic [CUR_W-1:0] step_x, step_y;
    logic [CUR_W-1:0] set_cx, set_cy;
    logic             pend_valid;
    logic [CUR_W-1:0] pend_x, pend_y;

    // Opposite keys cancel, so each axis contributes at most one active bit.
    assign go_right = dir_right & ~dir_left;
    assign go_left  = dir_left  & ~dir_right;
    assign go_down  = dir_down  & ~dir_up;
    assign go_up    = dir_up    & ~dir_down;
    assign dv       = {go_right, go_left, go_down, go_up};

    assign step_dx = go_right ? STEP_S : (go_left ? -STEP_S : '0);
    assign step_dy = go_down  ? STEP_S : (go_up   ? -STEP_S : '0);

    assign step_x = clamp_axis($signed({1'b0, cursorX}) + step_dx, X_MIN, X_MAX);
    assign step_y = clamp_axis($signed({1'b0, cursorY}) + step_dy, Y_MIN, Y_MAX);
    assign set_cx = clamp_axis($signed({1'b0, set_x}), X_MIN, X_MAX);
    assign set_cy = clamp_axis($signed({1'b0, set_y}), Y_MIN, Y_MAX);

    assign set_ready = ~frame_start;

    cursor_repeat_timer #(
        .HOLD_FRAMES  (HOLD_FRAMES),
        .REPEAT_FRAMES(REPEAT_FRAMES)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .frame_start(frame_start),
        .dv         (dv),
        .step_now   (step_now)
    );

    // A pending set wins over a step; the timer still advances either way.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cursorX    <= CUR_W'(W / 2);
            cursorY    <= CUR_W'(H / 2);
            moved      <= 1'b0;
            pend_valid <= 1'b0;
            pend_x     <= '0;
            pend_y     <= '0;
        end else begin
            moved <= 1'b0;
            if (set_valid && set_ready) begin
                pend_valid <= 1'b1;
                pend_x     <= set_cx;
                pend_y     <= set_cy;
            end
            if (frame_start) begin
                if (pend_valid) begin
                    cursorX    <= pend_x;
                    cursorY    <= pend_y;
                    pend_valid <= 1'b0;
                    moved      <= (pend_x != cursorX) || (pend_y != cursorY);
                end else if (step_now) begin
                    cursorX <= step_x;
                    cursorY <= step_y;
                    moved   <= (step_x != cursorX) || (step_y != cursorY);
                end
            end
        end
    end

endmodule

// File: tb/tb_cursor_position_ctrl.sv
// Self-checking bench for cursor_position_ctrl: directed scenarios then random keys/sets,
// compared against a frame-run-length reference model.
module tb_cursor_position_ctrl;

    localparam int HOLD_F = 15;
    localparam int REP_F  = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_start;
    logic        dir_up, dir_down, dir_left, dir_right;
    logic        set_valid;
    logic [10:0] set_x, set_y;
    logic        set_ready;
    logic [10:0] cursorX, cursorY;
    logic        moved;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    int m_x, m_y, m_px, m_py, run_k, prev_dx, prev_dy;
    bit m_pend, m_moved, run_active;

    cursor_position_ctrl #(
        .W(640), .H(480), .STEP(1), .HOLD_FRAMES(HOLD_F), .REPEAT_FRAMES(REP_F)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .frame_start(frame_start),
        .dir_up     (dir_up),
        .dir_down   (dir_down),
        .dir_left   (dir_left),
        .dir_right  (dir_right),
        .set_valid  (set_valid),
        .set_x      (set_x),
        .set_y      (set_y),
        .set_ready  (set_ready),
        .cursorX    (cursorX),
        .cursorY    (cursorY),
        .moved      (moved)
    );

    always #5 clk = ~clk;

    function automatic int clampi(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        m_x = 320; m_y = 240; m_pend = 0; m_moved = 0;
        run_active = 0; run_k = 0; prev_dx = 0; prev_dy = 0;
    endtask

    // Steps happen on the first frame of a run of identical non-zero key vectors,
    // then at HOLD frames into the run and every REPEAT frames after that.
    task automatic modelFrame();
        int dx, dy, ox, oy;
        bit step;
        dx = int'(dir_right) - int'(dir_left);
        dy = int'(dir_down) - int'(dir_up);
        step = 0;
        if (dx == 0 && dy == 0) begin
            run_active = 0;
        end else if (!run_active || dx != prev_dx || dy != prev_dy) begin
            run_active = 1; run_k = 0; step = 1;
        end else begin
            run_k++;
            step = (run_k >= HOLD_F) && (((run_k - HOLD_F) % REP_F) == 0);
        end
        prev_dx = dx; prev_dy = dy;
        ox = m_x; oy = m_y;
        if (m_pend) begin
            m_x = m_px; m_y = m_py; m_pend = 0;
        end else if (step) begin
            m_x = clampi(m_x + dx, 2, 636);
            m_y = clampi(m_y + dy, 2, 478);
        end
        m_moved = (m_x != ox) || (m_y != oy);
    endtask

    task automatic applyStimulus(input bit fs, input bit sv, input int sx, input int sy);
        frame_start = fs;
        set_valid   = sv;
        set_x       = 11'(sx);
        set_y       = 11'(sy);
        #1;
        checkOutput("set_ready", 32'(set_ready), 32'(!fs));
        @(posedge clk);
        #1;
        if (sv && !fs) begin
            m_pend = 1;
            m_px = clampi(sx, 2, 636);
            m_py = clampi(sy, 2, 478);
        end
        if (fs) modelFrame();
        else m_moved = 0;
        frame_start = 1'b0;
        set_valid   = 1'b0;
        checkOutput("cursorX", 32'(cursorX), 32'(m_x));
        checkOutput("cursorY", 32'(cursorY), 32'(m_y));
        checkOutput("moved", 32'(moved), 32'(m_moved));
    endtask

    task automatic frame(input int idle);
        applyStimulus(1, 0, 0, 0);
        for (int i = 0; i < idle; i++) applyStimulus(0, 0, 0, 0);
    endtask

    task automatic midReset();
        reset = 1'b1;
        #1;
        modelReset();
        checkOutput("reset_x", 32'(cursorX), 32'd320);
        checkOutput("reset_y", 32'(cursorY), 32'd240);
        checkOutput("reset_moved", 32'(moved), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic setDirs(input bit u, input bit d, input bit l, input bit r);
        dir_up = u; dir_down = d; dir_left = l; dir_right = r;
    endtask

    initial begin
        reset = 1'b1; frame_start = 1'b0; set_valid = 1'b0;
        set_x = '0; set_y = '0;
        setDirs(0, 0, 0, 0);
        modelReset();
        #12;
        checkOutput("init_x", 32'(cursorX), 32'd320);
        checkOutput("init_y", 32'(cursorY), 32'd240);
        checkOutput("init_ready", 32'(set_ready), 32'd1);
        checkOutput("init_moved", 32'(moved), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // single step right, moved pulses once
        setDirs(0, 0, 0, 1);
        frame(2);
        checkOutput("first_step_x", 32'(cursorX), 32'd321);

        // reset in the middle of a hold
        frame(1); frame(1); frame(1);
        midReset();
        checkOutput("post_reset_x", 32'(cursorX), 32'd320);

        // 25 held frames: steps at 0,15,18,21,24
        for (int i = 0; i < 25; i++) frame(1);
        checkOutput("hold25_x", 32'(cursorX), 32'd325);

        // out-of-range set is clamped and waits for frame_start
        setDirs(0, 0, 0, 0);
        applyStimulus(0, 1, 700, 0);
        checkOutput("set_pending_x", 32'(cursorX), 32'd325);
        frame(1);
        checkOutput("set_commit_x", 32'(cursorX), 32'd636);
        checkOutput("set_commit_y", 32'(cursorY), 32'd2);
        setDirs(0, 0, 1, 1);
        frame(1);
        checkOutput("lr_cancel_x", 32'(cursorX), 32'd636);

        // set on a frame_start cycle is refused, accepted the next cycle
        setDirs(0, 0, 0, 0);
        applyStimulus(1, 1, 50, 60);
        applyStimulus(0, 1, 50, 60);
        checkOutput("refused_set_x", 32'(cursorX), 32'd636);
        frame(1);
        checkOutput("late_set_x", 32'(cursorX), 32'd50);
        checkOutput("late_set_y", 32'(cursorY), 32'd60);

        // set wins over a step in the same frame; hold timing still starts
        applyStimulus(0, 1, 100, 100);
        setDirs(1, 0, 0, 0);
        frame(1);
        checkOutput("set_vs_step_y", 32'(cursorY), 32'd100);
        for (int i = 0; i < 14; i++) frame(0);
        checkOutput("hold14_y", 32'(cursorY), 32'd100);
        frame(1);
        checkOutput("hold15_y", 32'(cursorY), 32'd99);

        // direction change during repeat steps immediately
        setDirs(0, 0, 0, 1);
        for (int i = 0; i < 20; i++) frame(0);
        setDirs(0, 1, 0, 0);
        frame(1);
        checkOutput("dir_change_y", 32'(cursorY), 32'd100);
        frame(1); frame(1);
        checkOutput("rehold_y", 32'(cursorY), 32'd100);

        // pending set discarded by reset
        setDirs(0, 0, 0, 0);
        applyStimulus(0, 1, 10, 10);
        midReset();
        frame(1);
        checkOutput("pend_cleared_x", 32'(cursorX), 32'd320);

        // low clamp and step into the corner
        applyStimulus(0, 1, 0, 0);
        frame(1);
        checkOutput("low_clamp_x", 32'(cursorX), 32'd2);
        setDirs(1, 0, 1, 0);
        frame(1);
        checkOutput("corner_moved", 32'(moved), 32'd0);

        // random keys held for runs, random sets with random gaps
        for (int f = 0; f < 300; f++) begin
            if ($urandom_range(0, 7) == 0)
                setDirs(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            applyStimulus(1, ($urandom_range(0, 7) == 0), $urandom_range(0, 2047),
                          $urandom_range(0, 2047));
            for (int c = 0; c < int'($urandom_range(0, 3)); c++) begin
                if ($urandom_range(0, 3) == 0)
                    applyStimulus(0, 1, $urandom_range(0, 2047), $urandom_range(0, 2047));
                else
                    applyStimulus(0, 0, 0, 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
